// File: rtl/dcache_req_arbiter.sv
// Two-port arbiter in front of the single dcache request port, with an owner FIFO
// for response routing and port-0 squash on flush. Define DCACHE_ARB_RR_EN for round-robin.
module dcache_req_arbiter #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        p0_valid,
   output logic        p0_ready,
   input  logic        p0_op,
   input  logic [3:0]  p0_wstrb,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   input  logic        p0_atom,
   input  logic        p1_valid,
   output logic        p1_ready,
   input  logic        p1_op,
   input  logic [3:0]  p1_wstrb,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        dc_valid,
   input  logic        dc_ready,
   output logic        dc_op,
   output logic [3:0]  dc_wstrb,
   output logic [31:0] dc_addr,
   output logic [31:0] dc_wdata,
   output logic        dc_atom,
   input  logic        dc_resp_valid,
   input  logic [31:0] dc_rdata,
   output logic        p0_resp_valid,
   output logic [31:0] p0_rdata,
   output logic        p1_resp_valid,
   output logic [31:0] p1_rdata,
   output logic        busy
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [CW-1:0]    count_q, count_d;
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [DEPTH-1:0] own_q, own_d, kill_q, kill_d;
   logic             lock_q, lock_d, lock_own_q, lock_own_d;
   logic             last_q, last_d, busy_q, busy_d;
   logic             full, elig0, elig1, grant, req, hs, pop, head_own, head_kill;

   always_comb begin
      full  = (count_q == CW'(DEPTH));
      elig0 = p0_valid & ~flush & ~full;
      elig1 = p1_valid & ~full;
      grant = 1'b0;
      req   = 1'b0;
      if (lock_q) begin
         // A stalled port-0 request is withdrawn on flush; port 1 always holds.
         grant = lock_own_q;
         req   = ~(~lock_own_q & flush) & ~full;
      end else begin
         req = elig0 | elig1;
`ifdef DCACHE_ARB_RR_EN
         grant = (elig0 & elig1) ? ~last_q : elig1;
`else
         grant = elig1;
`endif
      end
   end

   assign dc_valid = req & ~rst;
   assign dc_op    = dc_valid & (grant ? p1_op : p0_op);
   assign dc_wstrb = dc_valid ? (grant ? p1_wstrb : p0_wstrb) : 4'h0;
   assign dc_addr  = dc_valid ? (grant ? p1_addr : p0_addr) : 32'h0;
   assign dc_wdata = dc_valid ? (grant ? p1_wdata : p0_wdata) : 32'h0;
   assign dc_atom  = dc_valid & ~grant & p0_atom;

   assign hs       = dc_valid & dc_ready;
   assign p0_ready = hs & ~grant;
   assign p1_ready = hs & grant;

   assign pop       = dc_resp_valid & (count_q != '0);
   assign head_own  = own_q[rd_q];
   assign head_kill = kill_q[rd_q];

   assign p0_resp_valid = pop & ~head_own & ~head_kill & ~flush & ~rst;
   assign p1_resp_valid = pop & head_own & ~rst;
   assign p0_rdata      = dc_rdata;
   assign p1_rdata      = dc_rdata;
   assign busy          = busy_q;

   always_comb begin
      lock_d     = dc_valid & ~dc_ready;
      lock_own_d = lock_d ? grant : lock_own_q;
      last_d     = hs ? grant : last_q;
      own_d      = own_q;
      kill_d     = kill_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (flush && !own_q[i]) kill_d[i] = 1'b1;
      end
      if (hs) begin
         own_d[wr_q]  = grant;
         kill_d[wr_q] = flush & ~grant;
      end
      wr_d = hs  ? wr_q + 1'b1 : wr_q;
      rd_d = pop ? rd_q + 1'b1 : rd_q;
      case ({hs, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      busy_d = (count_d != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q    <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         own_q      <= '0;
         kill_q     <= '0;
         lock_q     <= 1'b0;
         lock_own_q <= 1'b0;
         last_q     <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         count_q    <= count_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         own_q      <= own_d;
         kill_q     <= kill_d;
         lock_q     <= lock_d;
         lock_own_q <= lock_own_d;
         last_q     <= last_d;
         busy_q     <= busy_d;
      end
   end
endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Scenario bench for dcache_req_arbiter; response routing is checked against a scoreboard.
module tb_dcache_req_arbiter;
   logic        clk = 1'b0, rst = 1'b0, flush;
   logic        p0_valid, p0_ready, p0_op, p0_atom, p1_valid, p1_ready, p1_op;
   logic [3:0]  p0_wstrb, p1_wstrb, dc_wstrb;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata, dc_addr, dc_wdata, dc_rdata;
   logic        dc_valid, dc_ready, dc_op, dc_atom, dc_resp_valid;
   logic        p0_resp_valid, p1_resp_valid, busy;
   logic [31:0] p0_rdata, p1_rdata;

   int total = 0, bad = 0;

   typedef struct { logic port; logic kill; logic [31:0] data; } exp_t;
   exp_t sb[$];

   dcache_req_arbiter #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_op(p0_op), .p0_wstrb(p0_wstrb),
      .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_atom(p0_atom),
      .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_op(p1_op), .p1_wstrb(p1_wstrb),
      .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .dc_valid(dc_valid), .dc_ready(dc_ready), .dc_op(dc_op), .dc_wstrb(dc_wstrb),
      .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_atom(dc_atom),
      .dc_resp_valid(dc_resp_valid), .dc_rdata(dc_rdata),
      .p0_resp_valid(p0_resp_valid), .p0_rdata(p0_rdata),
      .p1_resp_valid(p1_resp_valid), .p1_rdata(p1_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      exp_t e;
      logic exp0, exp1;
      if (dc_resp_valid && !rst) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_empty: response with no expectation");
         end else begin
            e = sb.pop_front();
            exp0 = (e.port == 1'b0) && !e.kill;
            exp1 = (e.port == 1'b1);
            if (p0_resp_valid !== exp0 || p1_resp_valid !== exp1) begin
               bad++;
               $display("FAIL resp_route: got p0=%b p1=%b want p0=%b p1=%b", p0_resp_valid, p1_resp_valid, exp0, exp1);
            end
            if (exp0 || exp1) begin
               total++;
               if ((exp1 ? p1_rdata : p0_rdata) !== e.data) begin
                  bad++;
                  $display("FAIL resp_data: got %h want %h", exp1 ? p1_rdata : p0_rdata, e.data);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 0; p0_valid = 0; p1_valid = 0; dc_ready = 0; dc_resp_valid = 0; dc_rdata = 0;
      p0_op = 0; p0_atom = 0; p0_wstrb = 4'hF; p0_addr = 0; p0_wdata = 0;
      p1_op = 0; p1_wstrb = 4'hF; p1_addr = 0; p1_wdata = 0;
   endtask

   task automatic do_reset();
      idle();
      #2 rst = 1;
      #2 rst = 0;
      sb.delete();
      step();
   endtask

   task automatic test_reset();
      idle();
      rst = 1;
      #3;
      total++; if (dc_valid !== 0 || p0_ready !== 0 || p1_ready !== 0) begin bad++; $display("FAIL reset_req: dc_valid=%b rdy=%b%b want 0", dc_valid, p0_ready, p1_ready); end
      total++; if (busy !== 0 || p0_resp_valid !== 0 || p1_resp_valid !== 0) begin bad++; $display("FAIL reset_resp: busy=%b rv=%b%b want 0", busy, p0_resp_valid, p1_resp_valid); end
      rst = 0;
      step();
   endtask

   task automatic test_single_read();
      do_reset();
      p0_valid = 1; p0_addr = 32'h1C000100; dc_ready = 1;
      sb.push_back('{1'b0, 1'b0, 32'hDEADBEEF});
      #2;
      total++; if (p0_ready !== 1 || dc_valid !== 1) begin bad++; $display("FAIL single_ready: p0_ready=%b dc_valid=%b want 1", p0_ready, dc_valid); end
      total++; if (dc_addr !== 32'h1C000100) begin bad++; $display("FAIL single_addr: got %h want 1c000100", dc_addr); end
      for (int c = 1; c <= 4; c++) begin
         step();
         p0_valid = 0;
         dc_resp_valid = (c == 3);
         dc_rdata = (c == 3) ? 32'hDEADBEEF : 32'h0;
         #2;
         total++; if (busy !== (c != 4)) begin bad++; $display("FAIL single_busy c%0d: got %b want %b", c, busy, c != 4); end
      end
      dc_resp_valid = 0;
   endtask

   task automatic test_conflict();
      logic exp_g;
      do_reset();
      p0_valid = 1; p1_valid = 1; dc_ready = 1; p0_addr = 32'hA0; p1_addr = 32'hB0;
      for (int i = 0; i < 4; i++) begin
`ifdef DCACHE_ARB_RR_EN
         exp_g = (i % 2 == 1);
`else
         exp_g = 1'b1;
`endif
         sb.push_back('{exp_g, 1'b0, 32'h1000 + i});
         #2;
         total++; if (p0_ready !== !exp_g || p1_ready !== exp_g) begin bad++; $display("FAIL conflict_grant%0d: rdy=%b%b want p1=%b", i, p0_ready, p1_ready, exp_g); end
         step();
      end
      p0_valid = 0; p1_valid = 0;
      for (int i = 0; i < 4; i++) begin
         dc_resp_valid = 1; dc_rdata = 32'h1000 + i;
         step();
      end
      dc_resp_valid = 0;
   endtask

   task automatic test_stall();
      do_reset();
      p0_valid = 1; p0_addr = 32'h1C0000A4; p1_addr = 32'h2000_0040; dc_ready = 0;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) p1_valid = 1;
         #2;
         total++; if (dc_valid !== 1 || p0_ready !== 0 || p1_ready !== 0 || dc_addr !== 32'h1C0000A4) begin
            bad++; $display("FAIL stall_hold%0d: v=%b rdy=%b%b addr=%h want 1/00/1c0000a4", c, dc_valid, p0_ready, p1_ready, dc_addr); end
         step();
      end
      dc_ready = 1;
      sb.push_back('{1'b0, 1'b0, 32'h11});
      #2;
      total++; if (p0_ready !== 1 || p1_ready !== 0) begin bad++; $display("FAIL stall_release: rdy=%b%b want 10", p0_ready, p1_ready); end
      step();
      p0_valid = 0;
      sb.push_back('{1'b1, 1'b0, 32'h22});
      #2;
      total++; if (p1_ready !== 1 || dc_addr !== 32'h2000_0040) begin bad++; $display("FAIL stall_p1: p1_ready=%b addr=%h want 1/20000040", p1_ready, dc_addr); end
      step();
      p1_valid = 0; dc_ready = 0;
      dc_resp_valid = 1; dc_rdata = 32'h11; step();
      dc_rdata = 32'h22; step();
      dc_resp_valid = 0;
   endtask

   task automatic test_full();
      do_reset();
      p0_valid = 1; dc_ready = 1;
      for (int i = 0; i < 4; i++) begin
         p0_addr = 32'h300 + 4 * i;
         sb.push_back('{1'b0, 1'b0, 32'h500 + i});
         step();
      end
      p0_addr = 32'h400; dc_resp_valid = 1; dc_rdata = 32'h500;
      #2;
      total++; if (dc_valid !== 0 || p0_ready !== 0) begin bad++; $display("FAIL full_block: dc_valid=%b p0_ready=%b want 0", dc_valid, p0_ready); end
      step();
      dc_resp_valid = 0;
      sb.push_back('{1'b0, 1'b0, 32'h504});
      #2;
      total++; if (p0_ready !== 1 || dc_addr !== 32'h400) begin bad++; $display("FAIL full_next: p0_ready=%b addr=%h want 1/400", p0_ready, dc_addr); end
      step();
      p0_valid = 0;
      for (int i = 1; i <= 4; i++) begin
         dc_resp_valid = 1; dc_rdata = 32'h500 + i;
         step();
      end
      dc_resp_valid = 0;
   endtask

   task automatic test_flush();
      do_reset();
      dc_ready = 1;
      p0_valid = 1; sb.push_back('{1'b0, 1'b1, 32'h0}); step();
      p0_valid = 0; p1_valid = 1; sb.push_back('{1'b1, 1'b0, 32'hCAFE}); step();
      p1_valid = 0; p0_valid = 1; sb.push_back('{1'b0, 1'b1, 32'h0}); step();
      p0_valid = 1; flush = 1;
      #2;
      total++; if (dc_valid !== 0) begin bad++; $display("FAIL flush_block: dc_valid=%b want 0", dc_valid); end
      step();
      flush = 0; p0_valid = 0;
      dc_resp_valid = 1; dc_rdata = 32'h1111; step();
      dc_rdata = 32'hCAFE; step();
      dc_rdata = 32'h3333; step();
      dc_resp_valid = 0;
      #2;
      total++; if (busy !== 0) begin bad++; $display("FAIL flush_busy: got %b want 0", busy); end
      p0_valid = 1; sb.push_back('{1'b0, 1'b1, 32'h0}); step();
      p0_valid = 0; flush = 1; dc_resp_valid = 1; dc_rdata = 32'h4444; step();
      flush = 0; dc_resp_valid = 0;
   endtask

   task automatic test_async_reset();
      do_reset();
      p0_valid = 1; p0_addr = 32'h60; dc_ready = 1;
      sb.push_back('{1'b0, 1'b0, 32'h0}); step();
      dc_ready = 0; step();
      p1_valid = 1; step();
      #1 rst = 1;
      #1;
      total++; if (dc_valid !== 0 || busy !== 0 || p0_ready !== 0 || p1_ready !== 0) begin
         bad++; $display("FAIL arst_out: v=%b busy=%b rdy=%b%b want 0", dc_valid, busy, p0_ready, p1_ready); end
      rst = 0;
      sb.delete();
      dc_ready = 1;
      #1;
`ifdef DCACHE_ARB_RR_EN
      total++; if (p0_ready !== 1 || p1_ready !== 0) begin bad++; $display("FAIL arst_grant: rdy=%b%b want 10", p0_ready, p1_ready); end
`else
      total++; if (p0_ready !== 0 || p1_ready !== 1) begin bad++; $display("FAIL arst_grant: rdy=%b%b want 01", p0_ready, p1_ready); end
`endif
      step();
      #1;
      total++; if (busy !== 1) begin bad++; $display("FAIL arst_busy: got %b want 1", busy); end
      idle();
      do_reset();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_conflict();
      test_stall();
      test_full();
      test_flush();
      test_async_reset();
      step();
      total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover: %0d entries want 0", sb.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dcache_req_arbiter.md
# dcache_req_arbiter

Shares the single data-cache request port between two requesters: port 0 is the EX1 load/store path, and port 1 is the CACOP/privileged data-cache path. It arbitrates requests, keeps a granted-but-stalled request stable, and tracks outstanding requests in an owner FIFO so each response goes back to its issuer. On pipeline flush it squashes port-0 traffic that has not yet returned. It sits between EX1 and the dcache.

## Interface
Parameters:
- DEPTH, 4, maximum outstanding accepted-but-unanswered requests; power of 2, 2..16.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- flush  in  1  pipeline flush (branch mispredict / ERTN); kills port-0 traffic
- p0_valid, p1_valid  in  1  request valid
- p0_ready, p1_ready  out  1  request accepted this cycle
- p0_op, p1_op  in  1  0 read, 1 write
- p0_wstrb, p1_wstrb  in  4  byte strobe (0001 byte / 0011 half / 1111 word)
- p0_addr, p1_addr  in  32  address
- p0_wdata, p1_wdata  in  32  write data
- p0_atom  in  1  atomic (LL/SC); port 1 is never atomic
- dc_valid  out  1  request to dcache
- dc_ready  in  1  dcache accepts request
- dc_op, dc_wstrb, dc_addr, dc_wdata, dc_atom  out  1/4/32/32/1  muxed request fields
- dc_resp_valid  in  1  dcache response, in request order
- dc_rdata  in  32  response data (don't-care for writes)
- p0_resp_valid, p1_resp_valid  out  1  routed response
- p0_rdata, p1_rdata  out  32  routed data; equals dc_rdata
- busy  out  1  owner FIFO non-empty

## Operation
- Grant state: lock (1b), lock_owner (1b), last_grant (1b), owner FIFO of DEPTH entries {owner, kill}, count of width log2(DEPTH)+1.
- Eligibility:
  - Port 1 is eligible when p1_valid=1 and count<DEPTH.
  - Port 0 is eligible when p0_valid=1, flush=0 and count<DEPTH.
  - A same-cycle pop does not free a slot for a push.
- lock=1: the grant goes to lock_owner. If lock_owner=0 and flush=1, dc_valid=0 and lock clears; the dcache tolerates this withdrawal. Otherwise the fields stay stable until dc_ready.
- lock=0: choose between the eligible ports using the arbitration policy (see Configuration). If neither port is eligible, dc_valid=0.
- Handshakes:
  - dc_valid is asserted for the selected port, and dc_* fields mux from that port.
  - pX_ready = dc_valid & dc_ready & (grant==X).
  - dc_atom = p0_atom when the grant is port 0, otherwise 0.
- Lock update: lock sets when dc_valid & ~dc_ready, recording the owner. It clears on the handshake.
- On handshake:
  - Push {owner=grant, kill=0} into the FIFO.
  - Set last_grant=grant.
- On dc_resp_valid:
  - Pop the head entry.
  - Assert p{owner}_resp_valid unless kill=1 (a killed response is silently consumed).
  - If dc_resp_valid arrives with an empty FIFO, it is dropped and the FIFO/count are unchanged.
- flush: sets kill on every valid FIFO entry with owner=0.
  - Applies to entries present at the start of the cycle, and to any port-0 entry pushed in the same cycle. No port-0 push can occur during flush, since eligibility excludes it.
  - A port-0 response popping in the flush cycle is also suppressed.
- Port-1 entries and responses are never affected by flush.
- Response rules:
  - Write responses are routed exactly like reads.
  - pX_resp_valid never asserts unless the matching pX request was accepted earlier.

## Timing
- Reset values: all outputs 0, lock=0, last_grant=1, count=0, all FIFO entries invalid.
- Request path is combinational. dc_valid can rise in the same cycle as pX_valid, so there is 0-cycle arbitration latency.
- Response routing is combinational: pX_resp_valid appears in the same cycle as dc_resp_valid.
- count updates at the clock edge: +1 on handshake, −1 on pop, net 0 when both occur.
- busy is registered (count!=0).
- Full (count==DEPTH): dc_valid=0 and both readies are 0. This holds even if a pop occurs in that cycle.
- Reset asserted mid-operation: the FIFO clears immediately. The arbiter does not track responses arriving after reset; the dcache is reset concurrently.

## Configuration
- DCACHE_ARB_RR_EN defined: round-robin. On conflict, the port ≠ last_grant wins.
- DCACHE_ARB_RR_EN undefined: fixed priority, port 1 (CACOP) always beats port 0. last_grant is still maintained but unused.

## Test plan
- Single port-0 read, addr 0x1C000100, dc_ready=1: p0_ready in cycle 0; dc_resp_valid in cycle 3 with rdata 0xDEADBEEF -> p0_resp_valid=1, p0_rdata=0xDEADBEEF, busy=1 in cycles 1–3, busy=0 in cycle 4.
- Conflict, both valid every cycle for 4 grants: with RR_EN, grants are 0,1,0,1; without it, 1,1,1,1.
- Stall: port 0 granted, dc_ready=0 for 3 cycles while p1_valid rises. The grant stays with port 0 and dc_addr is stable. Port 1 is granted the cycle after the port-0 handshake.
- Full: DEPTH=4 accepted with no responses. The 5th request sees dc_valid=0. A response in that cycle does not allow a push; the push happens in the next cycle.
- Flush: two port-0 reads and one port-1 read outstanding (order p0,p1,p0), then flush=1. Three responses return: only p1_resp_valid pulses, for the second response. count returns to 0.
- Async reset mid-stall (rst pulse between clock edges): outputs go to 0 immediately, count=0, and the first grant after reset goes to port 0 under RR.
